systolic_drain: RTL and testbench
=================================

// Module: systolic_drain
// PURPOSE
// - Output collector at the bottom edge of the weight-stationary systolic array: captures each column's
//   out_sum stream, removes the per-column skew, and delivers one aligned result vector per input row.
// - Buffers results in a small FIFO and hands them downstream over a valid/ready handshake; the array
//   itself is never stalled, so overflow is detected and flagged, not back-pressured.
// PARAMETERS
// - DATA_SIZE   32  width of one column result (matches PE out_sum width)
// - COLS        4   number of array columns drained (>=1)
// - SKEW        4   cycles between column c and column c+1 results (PE madd latency 3 + output reg 1)
// - FIFO_DEPTH  4   aligned-vector FIFO entries (power of 2, >=2)
// PORTS
// - clk        in   1               rising-edge clock
// - reset_n    in   1               synchronous, active-low reset
// - in_sum     in   COLS*DATA_SIZE  bottom-row out_sum, column c at bits [c*DATA_SIZE +: DATA_SIZE]
// - in_valid   in   COLS            per-column result-valid (bottom-row enable, delayed to match out_sum)
// - out_vec    out  COLS*DATA_SIZE  aligned result vector, same column packing as in_sum
// - out_valid  out  1               out_vec holds a vector
// - out_ready  in   1               downstream accepts out_vec this cycle
// - vec_count  out  16              vectors accepted downstream since reset, wraps 0xFFFF->0
// - overflow   out  1               sticky: aligned vector arrived with FIFO full and no pop
// - skew_err   out  1               sticky: column valid bits disagreed after deskew
// BEHAVIOUR
// - Reset (reset_n=0 at posedge): delay lines, valid tags, FIFO pointers/count, vec_count, overflow,
//   skew_err, out_valid all cleared to 0; out_vec driven 0. Reset mid-stream discards everything in flight.
// - Input stage: in_sum/in_valid registered every cycle (1 cycle).
// - Deskew: column c (data+valid) delayed by (COLS-1-c)*SKEW further cycles in a shift line; column
//   COLS-1 has zero extra delay. Delay lines always shift (no enable); in-flight results never lost.
// - Alignment check on deskewed valids V[COLS-1:0]:
//   all 1 -> push vector; all 0 -> idle; mixed -> no push, skew_err<=1 (sticky until reset).
// - FIFO: registered, no fall-through. Push in cycle T -> out_valid=1 from T+1. Latency from last
//   column sample on in_sum to out_valid = 2 cycles when FIFO empty.
// - Pop when out_valid && out_ready; out_vec/out_valid stable while out_valid && !out_ready.
// - Full + push + pop same cycle: both happen, count unchanged, no overflow.
// - Full + push, no pop: vector dropped, FIFO contents unchanged, overflow<=1 (sticky).
// - Empty: out_valid=0, out_vec holds 0; pop ignored.
// - vec_count increments by 1 on each pop; wraps modulo 2^16.
// - Arithmetic: none on data in default build; values passed bit-exact.
// CONFIGURATION
// - DRAIN_RELU_EN defined: each column value treated as signed two's complement at FIFO write;
//   negative (MSB=1) replaced by 0, non-negative unchanged. No added latency.
// - DRAIN_RELU_EN undefined: data passed unmodified.
// TESTING (COLS=4, SKEW=4, FIFO_DEPTH=4, DATA_SIZE=32)
// - Single row: col c value 10+c with in_valid[c]=1 at cycle 4c (c=0..3), out_ready=1 -> out_valid at
//   cycle 14 for 1 cycle, out_vec={13,12,11,10}, vec_count=1, no flags.
// - Back-to-back: 6 rows on consecutive cycles, out_ready=1 -> 6 vectors in order, consecutive cycles.
// - Backpressure: out_ready=0, 5 rows -> first 4 held, 5th dropped, overflow=1; then out_ready=1 ->
//   exactly 4 vectors out in order, vec_count=4, overflow stays 1.
// - Misalignment: col 2 valid one cycle late -> no vector output, skew_err=1; subsequent correctly
//   skewed row still delivered.
// - Reset mid-stream: reset_n=0 for 1 cycle while 2 rows in flight -> all outputs 0, no vectors appear.
// - DRAIN_RELU_EN: column values {-5,7,0,0x80000000} -> out_vec {0,7,0,0}; without macro unchanged.

Source files
------------

// File: rtl/systolic_drain.sv
// systolic_drain: bottom-edge collector for the weight-stationary systolic array.
// Registers each column's result stream, removes the per-column skew so that one
// input row becomes one aligned vector, and buffers the vectors in a small FIFO
// with a valid/ready output. The array is never stalled: a vector arriving while
// the FIFO is full (and nothing pops) is dropped and flagged via 'overflow'.
// Optional feature macro: DRAIN_RELU_EN -- clamp negative column values to 0 at
// the FIFO write (no extra latency). Undefined: data is passed bit-exact.
module systolic_drain #(
    parameter int DATA_SIZE  = 32,
    parameter int COLS       = 4,
    parameter int SKEW       = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [COLS*DATA_SIZE-1:0] in_sum,
    input  logic [COLS-1:0]           in_valid,
    output logic [COLS*DATA_SIZE-1:0] out_vec,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [15:0]               vec_count,
    output logic                      overflow,
    output logic                      skew_err
);

    localparam int VW = COLS * DATA_SIZE;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]   ONE_CNT  = (AW + 1)'(1);
    localparam logic [AW-1:0] ONE_PTR  = AW'(1);

`ifdef DRAIN_RELU_EN
    // Negative two's-complement values are clamped to zero.
    function automatic logic [DATA_SIZE-1:0] relu(input logic signed [DATA_SIZE-1:0] x);
        logic [DATA_SIZE-1:0] y;
        y = x[DATA_SIZE-1] ? '0 : x;
        return y;
    endfunction
`endif

    // ---- stage p0: input capture ----
    logic [VW-1:0]   r_in_sum_p0;
    logic [COLS-1:0] r_in_vld_p0;

    // Register the bottom-row results every cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_in_sum_p0 <= '0;
            r_in_vld_p0 <= '0;
        end else begin
            r_in_sum_p0 <= in_sum;
            r_in_vld_p0 <= in_valid;
        end
    end

    // ---- stage p1: deskewed column view ----
    logic [VW-1:0]   w_al_sum_p1;
    logic [COLS-1:0] w_al_vld_p1;

    // Earlier columns produce their result earlier, so they wait longer: column c
    // is delayed by (COLS-1-c)*SKEW cycles; the last column passes straight through.
    for (genvar c = 0; c < COLS; c++) begin : g_col
        localparam int D = (COLS - 1 - c) * SKEW;
        if (D == 0) begin : g_direct
            assign w_al_sum_p1[c*DATA_SIZE +: DATA_SIZE] = r_in_sum_p0[c*DATA_SIZE +: DATA_SIZE];
            assign w_al_vld_p1[c]                        = r_in_vld_p0[c];
        end else begin : g_line
            logic [DATA_SIZE-1:0] r_sum_line [D];
            logic [D-1:0]         r_vld_line;

            // Free-running shift line; never stalls so no result is lost in flight.
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    for (int k = 0; k < D; k++) begin
                        r_sum_line[k] <= '0;
                        r_vld_line[k] <= 1'b0;
                    end
                end else begin
                    r_sum_line[0] <= r_in_sum_p0[c*DATA_SIZE +: DATA_SIZE];
                    r_vld_line[0] <= r_in_vld_p0[c];
                    for (int k = 1; k < D; k++) begin
                        r_sum_line[k] <= r_sum_line[k-1];
                        r_vld_line[k] <= r_vld_line[k-1];
                    end
                end
            end

            assign w_al_sum_p1[c*DATA_SIZE +: DATA_SIZE] = r_sum_line[D-1];
            assign w_al_vld_p1[c]                        = r_vld_line[D-1];
        end
    end

    logic          w_all_vld;
    logic          w_any_vld;
    logic [VW-1:0] w_wr_vec;

    assign w_all_vld = &w_al_vld_p1;
    assign w_any_vld = |w_al_vld_p1;

`ifdef DRAIN_RELU_EN
    // Per-column clamp applied on the FIFO write data.
    always_comb begin
        w_wr_vec = '0;
        for (int c = 0; c < COLS; c++) begin
            w_wr_vec[c*DATA_SIZE +: DATA_SIZE] = relu(w_al_sum_p1[c*DATA_SIZE +: DATA_SIZE]);
        end
    end
`else
    assign w_wr_vec = w_al_sum_p1;
`endif

    // ---- stage p2: aligned-vector FIFO ----
    logic [VW-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic [15:0]   r_vec_count;
    logic          r_overflow;
    logic          r_skew_err;

    logic w_pop;
    logic w_full;
    logic w_wr_en;
    logic w_drop;

    assign w_pop   = (r_count != '0) && out_ready;
    assign w_full  = (r_count == FULL_CNT);
    assign w_wr_en = w_all_vld && (!w_full || w_pop);
    assign w_drop  = w_all_vld && w_full && !w_pop;

    // Storage: written only when an aligned vector is accepted.
    always_ff @(posedge clk) begin
        if (reset_n && w_wr_en) begin
            r_mem[r_wptr] <= w_wr_vec;
        end
    end

    // Pointers, occupancy, pop counter and sticky error flags.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_vec_count <= '0;
            r_overflow  <= 1'b0;
            r_skew_err  <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wptr <= r_wptr + ONE_PTR;
            end
            if (w_pop) begin
                r_rptr      <= r_rptr + ONE_PTR;
                r_vec_count <= r_vec_count + 16'd1;
            end
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + ONE_CNT;
                2'b01:   r_count <= r_count - ONE_CNT;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_any_vld && !w_all_vld) begin
                r_skew_err <= 1'b1;
            end
        end
    end

    assign out_valid = (r_count != '0);
    assign out_vec   = out_valid ? r_mem[r_rptr] : '0;
    assign vec_count = r_vec_count;
    assign overflow  = r_overflow;
    assign skew_err  = r_skew_err;

endmodule

// File: tb/tb_systolic_drain.sv
// Scoreboard bench for systolic_drain (COLS=4, SKEW=4, FIFO_DEPTH=4, DATA_SIZE=32).
// Stimulus pushes expected vectors when a row is fully issued; a monitor on the
// falling edge pops and compares every vector the DUT hands over.
module tb_systolic_drain;

    logic         clk;
    logic         reset_n;
    logic [127:0] in_sum;
    logic [3:0]   in_valid;
    logic [127:0] out_vec;
    logic         out_valid;
    logic         out_ready;
    logic [15:0]  vec_count;
    logic         overflow;
    logic         skew_err;

    systolic_drain #(
        .DATA_SIZE(32), .COLS(4), .SKEW(4), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .reset_n(reset_n), .in_sum(in_sum), .in_valid(in_valid),
        .out_vec(out_vec), .out_valid(out_valid), .out_ready(out_ready),
        .vec_count(vec_count), .overflow(overflow), .skew_err(skew_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int npops, pop_first, pop_last, start;
    logic [127:0] exp_q [$];
    logic [127:0] mon_exp;

    int          rs   [8];
    logic [31:0] rv   [8][4];
    bit          rexp [8];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Monitor: every handed-over vector must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_vector: got %h expected none", out_vec);
            end else begin
                mon_exp = exp_q.pop_front();
                check("vector", out_vec, mon_exp);
            end
            if (npops == 0) pop_first = cyc;
            pop_last = cyc;
            npops++;
        end
    end

    // Drive rows: row r column c is presented at cycle rs[r]+4c (+1 for the late column).
    task automatic run_rows(input int nrows, input int ncyc, input int late_row, input int late_col);
        for (int t = 0; t < ncyc; t++) begin
            logic [127:0] s;
            logic [3:0]   v;
            s = '0;
            v = '0;
            for (int r = 0; r < nrows; r++) begin
                for (int c = 0; c < 4; c++) begin
                    int tc;
                    tc = rs[r] + 4 * c + ((r == late_row && c == late_col) ? 1 : 0);
                    if (t == tc) begin
                        v[c] = 1'b1;
                        s[c*32 +: 32] = rv[r][c];
                    end
                end
                if (t == rs[r] + 12 && rexp[r])
                    exp_q.push_back({rv[r][3], rv[r][2], rv[r][1], rv[r][0]});
            end
            in_sum   = s;
            in_valid = v;
            @(posedge clk);
            #1;
        end
        in_sum   = '0;
        in_valid = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        npops   = 0;
    endtask

    initial begin
        reset_n   = 1'b0;
        in_sum    = '0;
        in_valid  = '0;
        out_ready = 1'b1;
        npops     = 0;
        pop_first = 0;
        pop_last  = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Reset state
        check("rst_out_valid", out_valid, 0);
        check("rst_out_vec",   out_vec,   0);
        check("rst_vec_count", vec_count, 0);
        check("rst_overflow",  overflow,  0);
        check("rst_skew_err",  skew_err,  0);

        // Single row, values 10..13
        rs[0] = 0; rexp[0] = 1;
        rv[0][0] = 32'd10; rv[0][1] = 32'd11; rv[0][2] = 32'd12; rv[0][3] = 32'd13;
        npops = 0;
        start = cyc;
        run_rows(1, 20, -1, -1);
        check("single_latency",   pop_first - start, 14);
        check("single_npops",     npops, 1);
        check("single_vec_count", vec_count, 1);
        check("single_out_valid", out_valid, 0);
        check("single_overflow",  overflow, 0);
        check("single_skew_err",  skew_err, 0);

        // Back-to-back: 6 rows on consecutive cycles
        do_reset();
        for (int r = 0; r < 6; r++) begin
            rs[r] = r; rexp[r] = 1;
            for (int c = 0; c < 4; c++) rv[r][c] = 32'h1000 * (r + 1) + c;
        end
        start = cyc;
        run_rows(6, 25, -1, -1);
        check("b2b_npops",       npops, 6);
        check("b2b_first",       pop_first - start, 14);
        check("b2b_consecutive", pop_last - pop_first, 5);
        check("b2b_vec_count",   vec_count, 6);
        check("b2b_queue_empty", exp_q.size(), 0);

        // Backpressure: 5 rows into a 4-deep FIFO
        do_reset();
        out_ready = 1'b0;
        for (int r = 0; r < 5; r++) begin
            rs[r] = r; rexp[r] = (r < 4);
            for (int c = 0; c < 4; c++) rv[r][c] = 32'hA000 + 16 * r + c;
        end
        run_rows(5, 25, -1, -1);
        check("bp_out_valid_held", out_valid, 1);
        check("bp_head_vec", out_vec, {32'hA003, 32'hA002, 32'hA001, 32'hA000});
        check("bp_overflow", overflow, 1);
        check("bp_vec_count_hold", vec_count, 0);
        out_ready = 1'b1;
        run_rows(0, 10, -1, -1);
        check("bp_npops",       npops, 4);
        check("bp_vec_count",   vec_count, 4);
        check("bp_overflow_st", overflow, 1);
        check("bp_drained",     out_valid, 0);
        check("bp_queue_empty", exp_q.size(), 0);

        // Misalignment: row 0 column 2 one cycle late, row 1 correct
        do_reset();
        rs[0] = 0;  rexp[0] = 0;
        rs[1] = 20; rexp[1] = 1;
        for (int c = 0; c < 4; c++) begin
            rv[0][c] = 32'h5000 + c;
            rv[1][c] = 32'h6000 + c;
        end
        run_rows(2, 40, 0, 2);
        check("mis_skew_err",   skew_err, 1);
        check("mis_npops",      npops, 1);
        check("mis_vec_count",  vec_count, 1);
        check("mis_overflow",   overflow, 0);
        check("mis_queue_empty", exp_q.size(), 0);

        // Reset while two rows are in flight
        do_reset();
        rs[0] = 0; rexp[0] = 0;
        rs[1] = 1; rexp[1] = 0;
        for (int c = 0; c < 4; c++) begin
            rv[0][c] = 32'h7000 + c;
            rv[1][c] = 32'h8000 + c;
        end
        run_rows(2, 13, -1, -1);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        check("mrst_out_valid", out_valid, 0);
        check("mrst_out_vec",   out_vec, 0);
        check("mrst_vec_count", vec_count, 0);
        check("mrst_overflow",  overflow, 0);
        run_rows(0, 25, -1, -1);
        check("mrst_npops",    npops, 0);
        check("mrst_skew_err", skew_err, 0);

        // Signed values: clamped with DRAIN_RELU_EN, bit-exact otherwise
        do_reset();
        rs[0] = 0; rexp[0] = 0;
        rv[0][0] = 32'hFFFF_FFFB; rv[0][1] = 32'd7; rv[0][2] = 32'd0; rv[0][3] = 32'h8000_0000;
`ifdef DRAIN_RELU_EN
        exp_q.push_back({32'd0, 32'd0, 32'd7, 32'd0});
`else
        exp_q.push_back({32'h8000_0000, 32'd0, 32'd7, 32'hFFFF_FFFB});
`endif
        run_rows(1, 20, -1, -1);
        check("relu_npops",       npops, 1);
        check("relu_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
